// File: rtl/tx_protocol_pkg.sv
// Shared definitions for the transmit protocol block.
// Holds the transmit state encoding, ALERT register bit positions,
// TRANSMIT register field positions and the SOP type codes.
package tx_protocol_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CC,
        ST_SEND,
        ST_WAIT_CRC,
        ST_REPORT_SUCCESS,
        ST_REPORT_FAILED,
        ST_REPORT_DISCARDED
    } tx_state_e;

    // ALERT register bits owned by the transmitter.
    localparam int ALERT_TX_FAILED_BIT    = 4;
    localparam int ALERT_TX_DISCARDED_BIT = 5;
    localparam int ALERT_TX_SUCCESS_BIT   = 6;
    localparam int ALERT_STICKY_LSB       = ALERT_TX_FAILED_BIT;

    // TRANSMIT register fields.
    localparam int TRANSMIT_SOP_LSB   = 0;
    localparam int TRANSMIT_SOP_MSB   = 2;
    localparam int TRANSMIT_RETRY_LSB = 4;
    localparam int TRANSMIT_RETRY_MSB = 5;

    typedef enum logic [2:0] {
        SOP_SOP         = 3'd0,
        SOP_SOP_P       = 3'd1,
        SOP_SOP_PP      = 3'd2,
        SOP_DBG_P       = 3'd3,
        SOP_DBG_PP      = 3'd4,
        SOP_HARD_RESET  = 3'd5,
        SOP_CABLE_RESET = 3'd6
    } sop_type_e;

    // Hard Reset and Cable Reset are never acknowledged with GoodCRC.
    function automatic logic sop_skips_crc(input logic [2:0] sop);
        return (sop == SOP_HARD_RESET) || (sop == SOP_CABLE_RESET);
    endfunction

endpackage

// File: rtl/tx_protocol_if.sv
// Bus bundle between the transmit engine and its environment
// (register file, TX buffer, PHY, receive path).
//   master : transmit engine side (drives oALERT, oDIR_READ, oDATA_to_PHY,
//            oPHY_Valid, oTx_State_Machine_ACTIVE)
//   slave  : environment side (drives Start, iTRANSMIT, iTX_BYTE_COUNT,
//            iTX_BUF_DATA, iALERT, CC_IDLE, CC_Busy, PHY_Ready,
//            GoodCRC_Received, Rx_Message_Received)
interface tx_protocol_if;
    logic        Start;
    logic [7:0]  iTRANSMIT;
    logic [7:0]  iTX_BYTE_COUNT;
    logic [7:0]  iTX_BUF_DATA;
    logic [15:0] iALERT;
    logic        CC_IDLE;
    logic        CC_Busy;
    logic        PHY_Ready;
    logic        GoodCRC_Received;
    logic        Rx_Message_Received;
    logic [15:0] oALERT;
    logic [7:0]  oDIR_READ;
    logic [7:0]  oDATA_to_PHY;
    logic        oPHY_Valid;
    logic        oTx_State_Machine_ACTIVE;

    modport master (
        input  Start, iTRANSMIT, iTX_BYTE_COUNT, iTX_BUF_DATA, iALERT,
               CC_IDLE, CC_Busy, PHY_Ready, GoodCRC_Received, Rx_Message_Received,
        output oALERT, oDIR_READ, oDATA_to_PHY, oPHY_Valid, oTx_State_Machine_ACTIVE
    );

    modport slave (
        output Start, iTRANSMIT, iTX_BYTE_COUNT, iTX_BUF_DATA, iALERT,
               CC_IDLE, CC_Busy, PHY_Ready, GoodCRC_Received, Rx_Message_Received,
        input  oALERT, oDIR_READ, oDATA_to_PHY, oPHY_Valid, oTx_State_Machine_ACTIVE
    );
endinterface

// File: rtl/tx_protocol_crc_receive_timer.sv
// GoodCRC wait timer.
//   CLK, reset : clock, async active-low reset
//   clear      : forces the count to zero (has priority)
//   enable     : advance the count by one per cycle
//   expired    : count has reached CRC_TIMEOUT-1 (saturates there)
module crc_receive_timer #(
    parameter int CRC_TIMEOUT = 24
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(CRC_TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    assign expired = (count_q == CW'(CRC_TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable && !expired)
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/tx_protocol_module.sv
// Transmit protocol engine: waits for a clear line, streams the TX buffer
// to the PHY byte by byte, waits for GoodCRC with retries, and reports the
// outcome through sticky ALERT bits 6 (success), 5 (discarded), 4 (failed).
//   CLK, reset : clock, async active-low reset
//   bus        : tx_protocol_if.master (register, buffer, PHY and receive
//                path signals)
module tx_protocol_module
    import tx_protocol_pkg::*;
#(
    parameter int CRC_TIMEOUT = 24,
    parameter int MAX_BYTES   = 30
) (
    input  logic          CLK,
    input  logic          reset,
    tx_protocol_if.master bus
);
    tx_state_e   state_q, state_d;
    logic [7:0]  dir_q, dir_d;
    logic [7:0]  count_q, count_d;
    logic [2:0]  sop_q, sop_d;
    logic [1:0]  retries_q, retries_d;
    logic [2:0]  sticky_q, sticky_d;   // ALERT[6:4]
    logic [15:0] alert_q, alert_d;

    logic timer_clear, timer_en, timer_expired;
    logic handshake, last_byte, bad_count;

    assign timer_en    = (state_q == ST_WAIT_CRC);
    assign timer_clear = !timer_en;

    crc_receive_timer #(.CRC_TIMEOUT(CRC_TIMEOUT)) u_crc_timer (
        .CLK     (CLK),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    assign handshake = (state_q == ST_SEND) && bus.PHY_Ready;
    assign last_byte = (dir_q == count_q - 8'd1);
    assign bad_count = (bus.iTX_BYTE_COUNT == 8'd0) || (int'(bus.iTX_BYTE_COUNT) > MAX_BYTES);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        count_d   = count_q;
        sop_d     = sop_q;
        retries_d = retries_q;
        sticky_d  = sticky_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    sop_d     = bus.iTRANSMIT[TRANSMIT_SOP_MSB:TRANSMIT_SOP_LSB];
                    retries_d = bus.iTRANSMIT[TRANSMIT_RETRY_MSB:TRANSMIT_RETRY_LSB];
                    count_d   = bus.iTX_BYTE_COUNT;
                    sticky_d  = '0;
                    // An unusable length is rejected before touching the line.
                    state_d   = bad_count ? ST_REPORT_FAILED : ST_WAIT_CC;
                end
            end
            ST_WAIT_CC: begin
                // Every attempt, including retries, streams from address 0.
                dir_d = '0;
                if (bus.Rx_Message_Received)
                    state_d = ST_REPORT_DISCARDED;
                else if (bus.CC_IDLE && !bus.CC_Busy)
                    state_d = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    dir_d = dir_q + 8'd1;
                    if (last_byte)
                        state_d = sop_skips_crc(sop_q) ? ST_REPORT_SUCCESS : ST_WAIT_CRC;
                end
            end
            ST_WAIT_CRC: begin
                // GoodCRC wins over a simultaneous timeout.
                if (bus.GoodCRC_Received) begin
                    state_d = ST_REPORT_SUCCESS;
                end else if (timer_expired) begin
                    if (retries_q != 2'd0) begin
                        retries_d = retries_q - 2'd1;
                        state_d   = ST_WAIT_CC;
                    end else begin
                        state_d = ST_REPORT_FAILED;
                    end
                end
            end
            ST_REPORT_SUCCESS: begin
                sticky_d[ALERT_TX_SUCCESS_BIT - ALERT_STICKY_LSB] = 1'b1;
                state_d = ST_IDLE;
            end
            ST_REPORT_FAILED: begin
                sticky_d[ALERT_TX_FAILED_BIT - ALERT_STICKY_LSB] = 1'b1;
                state_d = ST_IDLE;
            end
            ST_REPORT_DISCARDED: begin
                sticky_d[ALERT_TX_DISCARDED_BIT - ALERT_STICKY_LSB] = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign alert_d = bus.iALERT | (16'(sticky_d) << ALERT_STICKY_LSB);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= '0;
            count_q   <= '0;
            sop_q     <= '0;
            retries_q <= '0;
            sticky_q  <= '0;
            alert_q   <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            count_q   <= count_d;
            sop_q     <= sop_d;
            retries_q <= retries_d;
            sticky_q  <= sticky_d;
            alert_q   <= alert_d;
        end
    end

    // Outputs decode straight from the state register so an asserted reset
    // clears them in the same cycle.
    assign bus.oALERT                   = alert_q;
    assign bus.oDIR_READ                = dir_q;
    assign bus.oPHY_Valid               = (state_q == ST_SEND);
    assign bus.oDATA_to_PHY             = bus.oPHY_Valid ? bus.iTX_BUF_DATA : 8'd0;
    assign bus.oTx_State_Machine_ACTIVE = (state_q != ST_IDLE);
endmodule

// File: tb/tb_tx_protocol_module.sv
// Scoreboard bench for tx_protocol_module: the driver computes the expected
// byte stream and final ALERT value from the protocol rules and queues them;
// an independent monitor pops and compares on every PHY handshake and on
// every end of transaction.
module tb_tx_protocol_module;
    import tx_protocol_pkg::*;

    localparam int CRC_TIMEOUT = 24;
    localparam int MAX_BYTES   = 30;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    tx_protocol_if bus();

    tx_protocol_module #(.CRC_TIMEOUT(CRC_TIMEOUT), .MAX_BYTES(MAX_BYTES)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] buf_mem [256];
    assign bus.iTX_BUF_DATA = buf_mem[bus.oDIR_READ];

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_byte_q [$];   // {address, data}
    logic [15:0] exp_res_q  [$];   // full expected oALERT at end of transaction

    int crc_d [4];                 // per-attempt GoodCRC delay; >= CRC_TIMEOUT means none

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int crc_at(input int a);
        return (a < 4) ? crc_d[a] : CRC_TIMEOUT;
    endfunction

    // Monitor
    initial begin
        logic prev_active, prev_stall;
        logic [7:0] prev_data, prev_addr;
        logic [15:0] e;
        prev_active = 1'b0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        prev_addr   = '0;
        forever begin
            @(negedge CLK);
            if (!reset) begin
                prev_active = 1'b0;
                prev_stall  = 1'b0;
                continue;
            end
            if (prev_stall && bus.oPHY_Valid) begin
                check("stall_data", bus.oDATA_to_PHY, prev_data);
                check("stall_addr", bus.oDIR_READ, prev_addr);
            end
            if (bus.oPHY_Valid && bus.PHY_Ready) begin
                if (exp_byte_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_byte: got addr %0h data %0h, no byte expected",
                             bus.oDIR_READ, bus.oDATA_to_PHY);
                end else begin
                    e = exp_byte_q.pop_front();
                    check("byte_addr", bus.oDIR_READ, e[15:8]);
                    check("byte_data", bus.oDATA_to_PHY, e[7:0]);
                end
            end
            if (prev_active && !bus.oTx_State_Machine_ACTIVE) begin
                if (exp_res_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_end: got alert %0h, no completion expected", bus.oALERT);
                end else begin
                    e = exp_res_q.pop_front();
                    check("alert_result", bus.oALERT, e);
                end
            end
            prev_stall  = bus.oPHY_Valid && !bus.PHY_Ready;
            prev_data   = bus.oDATA_to_PHY;
            prev_addr   = bus.oDIR_READ;
            prev_active = bus.oTx_State_Machine_ACTIVE;
        end
    end

    // One transaction: queue the expected outcome, then play the environment.
    task automatic run_txn(input int count, input int sop, input int retries,
                           input bit stall, input bit noise, input bit discard,
                           input int exp_cycles);
        logic [15:0] alert_in;
        logic [2:0]  res;
        int sends, hs, win, att, cyc_active, stall_left;
        bit done, prev_valid, in_send, hs_now;

        alert_in = 16'($urandom) & ~16'h0070;
        if (count == 0 || count > MAX_BYTES) begin
            sends = 0; res = 3'b001;
        end else if (discard) begin
            sends = 0; res = 3'b010;
        end else if (sop == 5 || sop == 6) begin
            sends = 1; res = 3'b100;
        end else begin
            sends = retries + 1; res = 3'b001;
            for (int i = 0; i <= retries; i++) begin
                if (crc_d[i] < CRC_TIMEOUT) begin
                    sends = i + 1; res = 3'b100;
                    break;
                end
            end
        end
        for (int s = 0; s < sends; s++)
            for (int b = 0; b < count; b++)
                exp_byte_q.push_back({8'(b), buf_mem[b]});
        exp_res_q.push_back(alert_in | {9'd0, res, 4'd0});

        @(posedge CLK); #1;
        bus.Start          = 1'b1;
        bus.iTRANSMIT      = {2'b00, 2'(retries), 1'b0, 3'(sop)};
        bus.iTX_BYTE_COUNT = 8'(count);
        bus.iALERT         = alert_in;
        @(posedge CLK); #1;
        bus.Start = 1'b0;

        hs = 0; win = 0; att = 0; cyc_active = 0; stall_left = 4;
        done = 1'b0; prev_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_send = prev_valid && (win == 0) && (hs < count);
            bus.GoodCRC_Received = (win > 0) ? (win == crc_at(att) + 1)
                                             : (noise && in_send && $urandom_range(0, 3) == 0);
            bus.Rx_Message_Received = discard ? (cyc >= 3)
                                              : (noise && in_send && $urandom_range(0, 3) == 0);
            bus.Start   = noise && in_send && $urandom_range(0, 3) == 0;
            bus.CC_Busy = discard ? 1'b1 : (noise && $urandom_range(0, 3) == 0);
            bus.CC_IDLE = noise ? ($urandom_range(0, 5) != 0) : 1'b1;
            if (stall && hs == 1 && stall_left > 0 && in_send) begin
                bus.PHY_Ready = 1'b0;
                stall_left--;
            end else begin
                bus.PHY_Ready = noise ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            @(negedge CLK);
            if (!bus.oTx_State_Machine_ACTIVE) begin
                done = 1'b1;
                break;
            end
            cyc_active++;
            hs_now     = bus.oPHY_Valid && bus.PHY_Ready;
            prev_valid = bus.oPHY_Valid;
            if (win > 0) begin
                if (bus.GoodCRC_Received) begin
                    win = 0; hs = count + 1;
                end else if (win == CRC_TIMEOUT) begin
                    win = 0; att++; hs = 0;
                end else begin
                    win++;
                end
            end
            if (hs_now) begin
                hs++;
                if (hs == count) win = 1;
            end
            @(posedge CLK); #1;
        end
        bus.Start = 1'b0; bus.GoodCRC_Received = 1'b0; bus.Rx_Message_Received = 1'b0;
        bus.CC_Busy = 1'b0; bus.CC_IDLE = 1'b1; bus.PHY_Ready = 1'b1;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL txn_timeout: got still active after 3000 cycles, required return to idle");
        end
        if (exp_cycles > 0) check("active_cycles", cyc_active, exp_cycles);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) buf_mem[i] = 8'($urandom);
        bus.Start = 1'b0; bus.iTRANSMIT = '0; bus.iTX_BYTE_COUNT = '0; bus.iALERT = 16'hFFFF;
        bus.CC_IDLE = 1'b1; bus.CC_Busy = 1'b0; bus.PHY_Ready = 1'b1;
        bus.GoodCRC_Received = 1'b0; bus.Rx_Message_Received = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_alert",  bus.oALERT, 16'h0);
        check("rst_dir",    bus.oDIR_READ, 8'h0);
        check("rst_data",   bus.oDATA_to_PHY, 8'h0);
        check("rst_valid",  bus.oPHY_Valid, 1'b0);
        check("rst_active", bus.oTx_State_Machine_ACTIVE, 1'b0);
        bus.iALERT = 16'h0;
        reset = 1'b1;
        repeat (2) @(posedge CLK);

        // Three bytes, GoodCRC on the 5th wait cycle
        buf_mem[0] = 8'hA1; buf_mem[1] = 8'hB2; buf_mem[2] = 8'hC3;
        crc_d = '{4, CRC_TIMEOUT, CRC_TIMEOUT, CRC_TIMEOUT};
        run_txn(3, 0, 0, 0, 0, 0, 10);

        // Two retries, no GoodCRC: three sends of 1+3+24 cycles, then report
        crc_d = '{CRC_TIMEOUT, CRC_TIMEOUT, CRC_TIMEOUT, CRC_TIMEOUT};
        run_txn(3, 1, 2, 0, 0, 0, 85);

        // Line busy and incoming message: discarded, no PHY traffic
        run_txn(3, 0, 0, 0, 0, 1, 5);

        // PHY stalls 4 cycles on byte 1
        crc_d = '{0, CRC_TIMEOUT, CRC_TIMEOUT, CRC_TIMEOUT};
        run_txn(4, 2, 0, 1, 0, 0, 1 + 4 + 4 + 1 + 1);

        // Zero length and oversize length fail immediately
        run_txn(0, 0, 3, 0, 0, 0, 1);
        run_txn(MAX_BYTES + 1, 0, 0, 0, 0, 0, 1);
        crc_d = '{1, CRC_TIMEOUT, CRC_TIMEOUT, CRC_TIMEOUT};
        run_txn(MAX_BYTES, 3, 0, 0, 0, 0, 1 + MAX_BYTES + 2 + 1);

        // GoodCRC on the timeout cycle of the second attempt counts as success
        crc_d = '{CRC_TIMEOUT, CRC_TIMEOUT - 1, CRC_TIMEOUT, CRC_TIMEOUT};
        run_txn(2, 0, 1, 0, 0, 0, 55);

        // Hard Reset / Cable Reset need no GoodCRC
        crc_d = '{CRC_TIMEOUT, CRC_TIMEOUT, CRC_TIMEOUT, CRC_TIMEOUT};
        run_txn(2, 5, 3, 0, 0, 0, 1 + 2 + 1);
        run_txn(3, 6, 0, 0, 0, 0, 1 + 3 + 1);

        // Reset while byte at address 1 is on the bus
        exp_byte_q.push_back({8'd0, buf_mem[0]});
        @(posedge CLK); #1;
        bus.Start = 1'b1; bus.iTRANSMIT = 8'h00; bus.iTX_BYTE_COUNT = 8'd5; bus.iALERT = 16'h0;
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        reset = 1'b0;
        #1;
        check("midrst_alert",  bus.oALERT, 16'h0);
        check("midrst_dir",    bus.oDIR_READ, 8'h0);
        check("midrst_data",   bus.oDATA_to_PHY, 8'h0);
        check("midrst_valid",  bus.oPHY_Valid, 1'b0);
        check("midrst_active", bus.oTx_State_Machine_ACTIVE, 1'b0);
        repeat (2) @(posedge CLK);
        exp_byte_q.delete();
        exp_res_q.delete();
        #1 reset = 1'b1;
        crc_d = '{2, CRC_TIMEOUT, CRC_TIMEOUT, CRC_TIMEOUT};
        run_txn(5, 0, 0, 0, 0, 0, 1 + 5 + 3 + 1);

        // Randomized traffic with line/PHY noise and ignored pulses
        for (int t = 0; t < 20; t++) begin
            int cnt;
            for (int a = 0; a < 4; a++) crc_d[a] = $urandom_range(0, CRC_TIMEOUT + 6);
            for (int i = 0; i < 256; i++) buf_mem[i] = 8'($urandom);
            cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_BYTES - 1, MAX_BYTES + 2)
                                              : $urandom_range(1, 8);
            run_txn(cnt, $urandom_range(0, 7), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 7) == 0), 0);
        end

        repeat (3) @(posedge CLK);
        check("bytes_left",   exp_byte_q.size(), 0);
        check("results_left", exp_res_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tx_protocol_module.md
TX_PROTOCOL_MODULE -- requirements
Module: tx_protocol_module

Interface
REQ-001 Parameter CRC_TIMEOUT, default 24, SHALL set the GoodCRC wait in CLK cycles.
REQ-002 Parameter MAX_BYTES, default 30, SHALL set the largest accepted iTX_BYTE_COUNT.
REQ-003 CLK  in  1  the single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  transmit request; sampled only in IDLE.
REQ-006 iTRANSMIT  in  8  bits 2:0 SOP type, bits 5:4 retry count (0-3).
REQ-007 iTX_BYTE_COUNT  in  8  number of buffer bytes to send.
REQ-008 iTX_BUF_DATA  in  8  buffer byte; a combinational function of oDIR_READ.
REQ-009 iALERT  in  16  current ALERT register value.
REQ-010 CC_IDLE, CC_Busy  in  1 each  line status from PHY.
REQ-011 PHY_Ready  in  1  PHY accepts the byte on oDATA_to_PHY this cycle.
REQ-012 GoodCRC_Received  in  1  one-cycle pulse from receive path.
REQ-013 Rx_Message_Received  in  1  incoming message detected by receive path.
REQ-014 oALERT  out  16  ALERT write-back value.
REQ-015 oDIR_READ  out  8  TX buffer read address.
REQ-016 oDATA_to_PHY  out  8  byte to PHY.
REQ-017 oPHY_Valid  out  1  oDATA_to_PHY is valid.
REQ-018 oTx_State_Machine_ACTIVE  out  1  high in every state except IDLE; feeds receive path.

Function
REQ-019 States SHALL be IDLE, WAIT_CC, SEND, WAIT_CRC, REPORT_SUCCESS, REPORT_FAILED, REPORT_DISCARDED.
REQ-020 In IDLE, Start=1 SHALL latch iTRANSMIT, iTX_BYTE_COUNT, retries_left=iTRANSMIT[5:4], clear oALERT[6:4] and go to WAIT_CC; Start outside IDLE SHALL be ignored.
REQ-021 A latched byte count of 0 or greater than MAX_BYTES SHALL go straight to REPORT_FAILED with no PHY traffic.
REQ-022 WAIT_CC SHALL move to SEND with oDIR_READ=0 when CC_IDLE=1 and CC_Busy=0; Rx_Message_Received=1 in WAIT_CC SHALL go to REPORT_DISCARDED and takes priority.
REQ-023 In SEND, oPHY_Valid SHALL be 1 and oDATA_to_PHY SHALL equal iTX_BUF_DATA; the byte SHALL hold stable while PHY_Ready=0.
REQ-024 On oPHY_Valid&PHY_Ready, oDIR_READ SHALL increment; the handshake on address count-1 SHALL deassert oPHY_Valid next cycle and enter WAIT_CRC with timer cleared.
REQ-025 Rx_Message_Received and GoodCRC_Received SHALL be ignored during SEND.
REQ-026 In WAIT_CRC, GoodCRC_Received=1 SHALL go to REPORT_SUCCESS; timer reaching CRC_TIMEOUT-1 SHALL go to WAIT_CC with retries_left-1 if retries_left>0, else REPORT_FAILED.
REQ-027 GoodCRC_Received coinciding with timer expiry SHALL count as success.
REQ-028 SOP types 5 (Hard Reset) and 6 (Cable Reset) SHALL skip WAIT_CRC and go to REPORT_SUCCESS after the last byte handshake.
REQ-029 Each REPORT state SHALL last one cycle, set sticky bit 6 (success), 4 (failed) or 5 (discarded) respectively, and return to IDLE.
REQ-030 oALERT SHALL be the registered value of iALERT OR the sticky bits [6:4]; sticky bits SHALL clear only on an accepted Start or reset.
REQ-031 Total attempts SHALL be 1 + iTRANSMIT[5:4]; every retry SHALL restart from address 0.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, oALERT=0, oDIR_READ=0, oDATA_to_PHY=0, oPHY_Valid=0, oTx_State_Machine_ACTIVE=0, timer=0, retries_left=0, sticky bits=0, including mid-SEND.

Structure
REQ-033 Package tx_protocol_pkg SHALL hold the state encoding, ALERT bit positions 4/5/6, TRANSMIT field positions and SOP type codes.
REQ-034 The GoodCRC timeout counter SHALL be a sub-module crc_receive_timer (clear, enable, expired).

Verification
REQ-035 Start, count=3, buffer {A1,B2,C3}, PHY_Ready=1, GoodCRC on the 5th WAIT_CRC cycle -> bytes A1,B2,C3 on three consecutive cycles, oALERT[6]=1, ACTIVE drops after REPORT.
REQ-036 retry=2, no GoodCRC -> three full sends, each followed by 24 WAIT_CRC cycles, then oALERT[4]=1.
REQ-037 CC_Busy=1 with Rx_Message_Received=1 in WAIT_CC -> no oPHY_Valid, oALERT[5]=1.
REQ-038 PHY_Ready held 0 for 4 cycles on byte 1 -> oDATA_to_PHY and oDIR_READ stable, no byte lost or repeated.
REQ-039 reset=0 during byte 2 of SEND -> all outputs at reset values that cycle; next Start sends from address 0.
REQ-040 count=0, and GoodCRC coinciding with timeout -> immediate oALERT[4]=1; oALERT[6]=1, not retry.
